// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard controller: a three-entry destination scoreboard (EX/MEM/WB)
// drives stall/flush, and saturating counters track stall episodes and cycles.
module hazard_stall_unit #(
  parameter bit FORWARD = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr_d,
  input  logic             valid_d,
  input  logic [1:0]       optype_d,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_e,
  output logic [CNT_W-1:0] stall_events,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_load;
  } sb_entry_t;

  localparam logic [0:0]       ST_RUN   = 1'b0;
  localparam logic [0:0]       ST_STALL = 1'b1;
  localparam logic [5:0]       OP_RTYPE = 6'b000000;
  localparam logic [5:0]       OP_LW    = 6'b100011;
  localparam sb_entry_t        SB_EMPTY = 7'b000_0000;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  // With forwarding only an EX load can hazard; without it EX and MEM both can.
  localparam logic [2:0]       HAZ_MASK = FORWARD ? 3'b001 : 3'b011;

  // Destination written by an instruction; $0 counts as no destination.
  function automatic sb_entry_t decode_dest(input logic [31:0] instr);
    sb_entry_t e;
    e = SB_EMPTY;
    case (instr[31:26])
      OP_RTYPE: begin
        e.valid = 1'b1;
        e.dest  = instr[15:11];
      end
      OP_LW: begin
        e.valid   = 1'b1;
        e.dest    = instr[20:16];
        e.is_load = 1'b1;
      end
      default: e = SB_EMPTY;
    endcase
    e.valid = e.valid & (e.dest != 5'd0);
    return e;
  endfunction

  function automatic logic sb_match(input sb_entry_t e, input logic [4:0] rs,
                                    input logic [4:0] rt);
    return e.valid && (e.dest != 5'd0) && ((e.dest == rs) || (e.dest == rt));
  endfunction

  sb_entry_t [2:0] sb_r;
  logic [0:0]      state_r;
  logic [0:0]      state_next_s;
  logic [4:0]      rs_s;
  logic [4:0]      rt_s;
  logic            check_s;
  logic [2:0]      match_s;
  logic            hazard_s;
  sb_entry_t       dest_s;
  sb_entry_t       ex_next_s;
  logic            unused_s;

  assign rs_s     = instr_d[25:21];
  assign rt_s     = instr_d[20:16];
  assign check_s  = valid_d && (optype_d != 2'b00);
  assign dest_s   = decode_dest(instr_d);
  assign unused_s = ^instr_d[10:0];

  // Per-entry source match, qualified by the forwarding mode.
  always_comb begin
    match_s = 3'b000;
    for (int i = 0; i < 3; i++) begin
      match_s[i] = check_s && sb_match(sb_r[i], rs_s, rt_s)
                   && (FORWARD ? sb_r[i].is_load : 1'b1);
    end
  end

  assign hazard_s = |(match_s & HAZ_MASK);
  assign stall_f  = hazard_s;
  assign stall_d  = hazard_s;
  assign flush_e  = hazard_s;

  // Next EX entry: the decoded destination, or a bubble when stalling or empty.
  always_comb begin
    if (!hazard_s && valid_d) begin
      ex_next_s = dest_s;
    end else begin
      ex_next_s = SB_EMPTY;
    end
  end

  // Scoreboard shift EX -> MEM -> WB; the WB entry drops off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_r <= {3{SB_EMPTY}};
    end else begin
      sb_r <= {sb_r[1], sb_r[0], ex_next_s};
    end
  end

  // RUN/STALL episode tracking.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN:   state_next_s = hazard_s ? ST_STALL : ST_RUN;
      ST_STALL: state_next_s = hazard_s ? ST_STALL : ST_RUN;
      default:  state_next_s = ST_RUN;
    endcase
  end

  // State register and saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_RUN;
      stall_events <= {CNT_W{1'b0}};
      stall_cycles <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      if ((state_r == ST_RUN) && hazard_s && (stall_events != CNT_MAX)) begin
        stall_events <= stall_events + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_events <= stall_events;
      end
      if (hazard_s && (stall_cycles != CNT_MAX)) begin
        stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cycles <= stall_cycles;
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench: three instances (no forwarding, forwarding, no forwarding with
// 4-bit counters) share one stimulus stream; expected stalls go through a queue.
module tb_hazard_stall_unit;

  localparam logic [31:0] ADD3  = 32'h0022_1820; // add $3,$1,$2
  localparam logic [31:0] SUB4  = 32'h0061_2022; // sub $4,$3,$1
  localparam logic [31:0] LW5   = 32'h8C25_0000; // lw  $5,0($1)
  localparam logic [31:0] ADD6  = 32'h00A2_3020; // add $6,$5,$2
  localparam logic [31:0] ADD7  = 32'h00C6_3820; // add $7,$6,$6
  localparam logic [31:0] ADD0  = 32'h0022_0020; // add $0,$1,$2
  localparam logic [31:0] RD0   = 32'h0000_2020; // add $4,$0,$0
  localparam logic [31:0] JRS5  = 32'h08A0_0000; // j with rs field = 5
  localparam logic [31:0] NOP   = 32'h0000_0000;

  typedef struct {
    logic  e0;
    logic  e1;
    string tag;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_d;
  logic        valid_d;
  logic [1:0]  optype_d;
  logic        sf0, sd0, fe0, sf1, sd1, fe1, sf2, sd2, fe2;
  logic [15:0] ev0, cy0, ev1, cy1;
  logic [3:0]  ev2, cy2;

  int   checks;
  int   errors;
  exp_t exp_q[$];

  hazard_stall_unit #(.FORWARD(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .valid_d(valid_d),
    .optype_d(optype_d), .stall_f(sf0), .stall_d(sd0), .flush_e(fe0),
    .stall_events(ev0), .stall_cycles(cy0));

  hazard_stall_unit #(.FORWARD(1'b1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .valid_d(valid_d),
    .optype_d(optype_d), .stall_f(sf1), .stall_d(sd1), .flush_e(fe1),
    .stall_events(ev1), .stall_cycles(cy1));

  hazard_stall_unit #(.FORWARD(1'b0), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .valid_d(valid_d),
    .optype_d(optype_d), .stall_f(sf2), .stall_d(sd2), .flush_e(fe2),
    .stall_events(ev2), .stall_cycles(cy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({e.tag, "_f0"}, {29'd0, sf0, sd0, fe0}, {29'd0, {3{e.e0}}});
      check({e.tag, "_f1"}, {29'd0, sf1, sd1, fe1}, {29'd0, {3{e.e1}}});
      check({e.tag, "_c4"}, {29'd0, sf2, sd2, fe2}, {29'd0, {3{e.e0}}});
    end
  endtask

  task automatic step(input logic [31:0] instr, input logic v, input logic [1:0] opt,
                      input logic e0, input logic e1, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    instr_d  = instr;
    valid_d  = v;
    optype_d = opt;
    e.e0 = e0;
    e.e1 = e1;
    e.tag = tag;
    exp_q.push_back(e);
    @(negedge clk);
    compare();
  endtask

  task automatic flush3();
    for (int i = 0; i < 3; i++) step(ADD6, 1'b0, 2'b10, 1'b0, 1'b0, "flush");
  endtask

  task automatic check_cnt(input string tag, input logic [15:0] e_ev0, input logic [15:0] e_cy0,
                           input logic [15:0] e_ev1, input logic [15:0] e_cy1,
                           input logic [3:0] e_ev2, input logic [3:0] e_cy2);
    check({tag, "_ev0"}, {16'd0, ev0}, {16'd0, e_ev0});
    check({tag, "_cy0"}, {16'd0, cy0}, {16'd0, e_cy0});
    check({tag, "_ev1"}, {16'd0, ev1}, {16'd0, e_ev1});
    check({tag, "_cy1"}, {16'd0, cy1}, {16'd0, e_cy1});
    check({tag, "_ev2"}, {28'd0, ev2}, {28'd0, e_ev2});
    check({tag, "_cy2"}, {28'd0, cy2}, {28'd0, e_cy2});
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    instr_d  = NOP;
    valid_d  = 1'b0;
    optype_d = 2'b00;
    #12;
    check("rst_out", {23'd0, sf0, sd0, fe0, sf1, sd1, fe1, sf2, sd2, fe2}, 32'd0);
    check_cnt("rst", 16'd0, 16'd0, 16'd0, 16'd0, 4'd0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // No forwarding: EX producer gives two stall cycles.
    step(ADD3, 1'b1, 2'b10, 1'b0, 1'b0, "a_add");
    step(SUB4, 1'b1, 2'b10, 1'b1, 1'b0, "a_sub1");
    step(SUB4, 1'b1, 2'b10, 1'b1, 1'b0, "a_sub2");
    step(SUB4, 1'b1, 2'b10, 1'b0, 1'b0, "a_sub3");
    check_cnt("a", 16'd1, 16'd2, 16'd0, 16'd0, 4'd1, 4'd2);
    flush3();

    // No forwarding: MEM producer gives one stall cycle.
    step(ADD3, 1'b1, 2'b10, 1'b0, 1'b0, "m_add");
    step(NOP,  1'b1, 2'b00, 1'b0, 1'b0, "m_nop");
    step(SUB4, 1'b1, 2'b10, 1'b1, 1'b0, "m_sub1");
    step(SUB4, 1'b1, 2'b10, 1'b0, 1'b0, "m_sub2");
    check_cnt("m", 16'd2, 16'd3, 16'd0, 16'd0, 4'd2, 4'd3);
    flush3();

    // Load-use, then a dependent R-type after it.
    step(LW5,  1'b1, 2'b01, 1'b0, 1'b0, "l_lw");
    step(ADD6, 1'b1, 2'b10, 1'b1, 1'b1, "l_add6a");
    step(ADD6, 1'b1, 2'b10, 1'b1, 1'b0, "l_add6b");
    step(ADD6, 1'b1, 2'b10, 1'b0, 1'b0, "l_add6c");
    step(ADD7, 1'b1, 2'b10, 1'b1, 1'b0, "l_add7a");
    step(ADD7, 1'b1, 2'b10, 1'b1, 1'b0, "l_add7b");
    step(ADD7, 1'b1, 2'b10, 1'b0, 1'b0, "l_add7c");
    check_cnt("l", 16'd4, 16'd7, 16'd1, 16'd1, 4'd4, 4'd7);
    flush3();

    // $0 destination and optype 00 consumer never stall.
    step(ADD0, 1'b1, 2'b10, 1'b0, 1'b0, "z_add0");
    step(RD0,  1'b1, 2'b10, 1'b0, 1'b0, "z_rd0");
    step(LW5,  1'b1, 2'b01, 1'b0, 1'b0, "z_lw");
    step(JRS5, 1'b1, 2'b00, 1'b0, 1'b0, "z_j");
    flush3();

    // Decode bubble with matching rs inserts an empty EX entry.
    step(LW5,  1'b1, 2'b01, 1'b0, 1'b0, "b_lw");
    step(ADD6, 1'b0, 2'b10, 1'b0, 1'b0, "b_bub");
    step(ADD6, 1'b1, 2'b10, 1'b1, 1'b0, "b_add6a");
    step(ADD6, 1'b1, 2'b10, 1'b0, 1'b0, "b_add6b");
    check_cnt("b", 16'd5, 16'd8, 16'd1, 16'd1, 4'd5, 4'd8);
    flush3();

    // Repeated episodes drive the 4-bit counters into saturation.
    for (int k = 0; k < 12; k++) begin
      step(ADD3, 1'b1, 2'b10, 1'b0, 1'b0, "s_add");
      step(SUB4, 1'b1, 2'b10, 1'b1, 1'b0, "s_sub1");
      step(SUB4, 1'b1, 2'b10, 1'b1, 1'b0, "s_sub2");
      step(SUB4, 1'b1, 2'b10, 1'b0, 1'b0, "s_sub3");
      if (k == 9) check_cnt("s10", 16'd15, 16'd28, 16'd1, 16'd1, 4'd15, 4'd15);
    end
    check_cnt("s12", 16'd17, 16'd32, 16'd1, 16'd1, 4'd15, 4'd15);
    flush3();

    // Reset asserted mid-stall drops the stall at once.
    step(ADD3, 1'b1, 2'b10, 1'b0, 1'b0, "r_add");
    step(SUB4, 1'b1, 2'b10, 1'b1, 1'b0, "r_sub1");
    #1;
    rst_n = 1'b0;
    #1;
    check("r_out", {23'd0, sf0, sd0, fe0, sf1, sd1, fe1, sf2, sd2, fe2}, 32'd0);
    check_cnt("r", 16'd0, 16'd0, 16'd0, 16'd0, 4'd0, 4'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(SUB4, 1'b1, 2'b10, 1'b0, 1'b0, "r_sub2");
    step(SUB4, 1'b1, 2'b10, 1'b0, 1'b0, "r_sub3");
    check_cnt("r_post", 16'd0, 16'd0, 16'd0, 16'd0, 4'd0, 4'd0);
    check("queue_drain", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Decode-stage hazard controller for the 5-stage pipeline; the consumer of the decode-stage operand-class code (`optype`). It tracks the destination registers of instructions in flight in EX, MEM and WB with a shift-register scoreboard. When the decode-stage instruction reads a register that is not yet available, it stalls fetch/decode and injects a bubble into EX. It also keeps stall-episode and stall-cycle performance counters.

## Interface
- `FORWARD`, default 1: 1 means the datapath forwards EX/MEM results, so only load-use hazards stall; 0 means no forwarding.
- `CNT_W`, default 16: width of the performance counters.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr_d`  in  32  instruction held in the IF/ID register.
- `valid_d`  in  1  the IF/ID register holds a real instruction (0 = bubble).
- `optype_d`  in  2  operand class of `instr_d`:
  - 2'b10: R-type.
  - 2'b01: lw, sw or beq.
  - 2'b00: other instructions; no sources are checked.
- `stall_f`  out  1  hold the PC.
- `stall_d`  out  1  hold IF/ID.
- `flush_e`  out  1  load a bubble into ID/EX.
- `stall_events`  out  CNT_W  number of RUN→STALL transitions; saturates at all-ones.
- `stall_cycles`  out  CNT_W  number of stalled cycles; saturates at all-ones.

## Operation
- **Decode fields:**
  - Sources: `rs = instr_d[25:21]`, `rt = instr_d[20:16]`.
  - Both sources are checked when `optype_d != 2'b00` (conservative for lw).
- **Destination of `instr_d`:**
  - Opcode 6'b000000 writes `rd = instr_d[15:11]`.
  - Opcode 6'b100011 writes `rt` and is flagged as a load.
  - All other opcodes have no destination.
  - A destination of register 0 is recorded as no destination.
- **Scoreboard:** three entries, EX, MEM and WB. Each entry holds {valid, dest[4:0], is_load}. It shifts every cycle: EX→MEM→WB, and the WB entry is discarded.
- **EX entry load value:**
  - Not stalling and `valid_d=1`: load the decoded destination.
  - Otherwise: load invalid.
- **Match rule:** an entry matches when it is valid, `dest != 0`, `optype_d != 0`, `valid_d=1`, and `dest == rs` or `dest == rt`.
- **Hazard, FORWARD=0:** match in EX or MEM. WB never hazards, because the register file is written in the first half-cycle and read in the second.
- **Hazard, FORWARD=1:** match in EX with `is_load=1`.
- **Outputs:** `stall_f = stall_d = flush_e = hazard`. These are combinational from the scoreboard registers and the decode inputs, so they are valid in the same cycle.
- **FSM, two states:** RUN and STALL.
  - RUN→STALL when hazard=1; `stall_events` increments.
  - STALL→RUN when hazard=0.
  - STALL stays in STALL while hazard=1.
- **`stall_cycles`:** increments in every cycle with hazard=1, in either state.
- **Counter arithmetic:** unsigned. At all-ones a counter holds its value; it does not wrap.

## Timing
- **Reset (asynchronous, on `rst_n`=0):**
  - All scoreboard entries invalid.
  - FSM in RUN.
  - Both counters 0.
  - `stall_f`/`stall_d`/`flush_e` are 0 while in reset and after it, until a hazard occurs.
- **Reset mid-stall:** reset drops the stall immediately (asynchronously). The in-flight scoreboard contents are lost. The pipeline registers are reset in the same event.
- **Stall durations, FORWARD=0** (back-to-back dependent pair):
  - Dependent on the EX producer: 2 stall cycles.
  - Dependent on the MEM producer: 1 stall cycle.
- **Stall durations, FORWARD=1:**
  - Load-use: exactly 1 stall cycle.
  - R-type to dependent R-type: 0 stall cycles.
- **Multiple matches:** a hazard in any entry stalls. One episode counts once, however long it lasts.
- **Bubbles:** a bubble in decode (`valid_d=0`) never stalls and inserts an invalid EX entry.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stall (FORWARD=0, producer in EX) -> outputs 0 immediately; counters 0; after release, the scoreboard is empty and no stall occurs.
- **No forwarding:** FORWARD=0, `add $3,$1,$2` (0x00221820) then `sub $4,$3,$1` -> `stall_d`=1 for 2 cycles, 1 bubble in EX per stall cycle, `stall_events`=1, `stall_cycles`=2.
- **Load-use:** FORWARD=1, `lw $5,0($1)` then `add $6,$5,$2` -> 1 stall cycle. Then `add $7,$6,$6` -> no stall.
- **Zero register and optype 00:** writes to $0, or a consumer with `optype_d`=00 (e.g. j) -> no stall in either FORWARD mode.
- **Saturation:** force repeated episodes with CNT_W=4 -> `stall_events` and `stall_cycles` stop at 15 and never wrap to 0.
- **Decode bubble:** `valid_d`=0 with matching rs -> no stall; an invalid EX entry is shifted in.
